// File: rtl/cmd_op_queue.sv
// Operator queue for the calculator front end: decodes ASCII operator bytes to a one-hot code
// and buffers up to DEPTH of them for the ALU sequencer, with invalid/underflow/overflow flags.
module cmd_op_queue #(
  parameter int unsigned DEPTH   = 4,
  parameter int unsigned AW      = 2,
  parameter int unsigned EXT_OPS = 1
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          load_cmd,
  input  logic          rdy,
  input  logic          got_dig,
  input  logic          flush,
  input  logic [7:0]    data,
  output logic [5:0]    out,
  output logic          out_valid,
  output logic [AW:0]   count,
  output logic          empty,
  output logic          full,
  output logic          err_invalid,
  output logic          err_underflow,
  output logic          err_overflow
);

  localparam logic [AW:0] CountMax = (AW+1)'(DEPTH);

  logic [5:0]    mem_q [DEPTH];
  logic [AW-1:0] wr_ptr_q, wr_ptr_d;
  logic [AW-1:0] rd_ptr_q, rd_ptr_d;
  logic [AW:0]   count_q, count_d;
  logic [5:0]    out_q, out_d;
  logic          out_valid_q, out_valid_d;
  logic          err_invalid_q, err_invalid_d;
  logic          err_underflow_q, err_underflow_d;
  logic          err_overflow_q, err_overflow_d;

  logic [5:0]    op_oh;
  logic          op_valid;
  logic          push_req;
  logic          pop_req;
  logic          wr_en;

  always_comb begin
    op_oh = 6'b000000;
    case (data)
      8'h2B:   op_oh = 6'b000001;
      8'h2D:   op_oh = 6'b000010;
      8'h2A:   op_oh = 6'b000100;
      8'h2F:   op_oh = 6'b001000;
      8'h25:   op_oh = (EXT_OPS != 0) ? 6'b010000 : 6'b000000;
      8'h5E:   op_oh = (EXT_OPS != 0) ? 6'b100000 : 6'b000000;
      default: op_oh = 6'b000000;
    endcase
  end

  assign op_valid = |op_oh;
  assign push_req = load_cmd & op_valid & ~flush;
  assign pop_req  = rdy & ~flush;

  always_comb begin
    wr_ptr_d        = wr_ptr_q;
    rd_ptr_d        = rd_ptr_q;
    count_d         = count_q;
    out_d           = out_q;
    out_valid_d     = out_valid_q;
    err_invalid_d   = 1'b0;
    err_underflow_d = 1'b0;
    err_overflow_d  = err_overflow_q;
    wr_en           = 1'b0;

    if (flush) begin
      wr_ptr_d       = '0;
      rd_ptr_d       = '0;
      count_d        = '0;
      out_d          = '0;
      out_valid_d    = 1'b0;
      err_overflow_d = 1'b0;
    end else begin
      err_invalid_d = load_cmd & ~op_valid;
      if (pop_req) begin
        if (count_q != '0) begin
          out_d       = mem_q[rd_ptr_q];
          out_valid_d = 1'b1;
          rd_ptr_d    = rd_ptr_q + 1'b1;
          // A same-cycle push reuses the slot being freed, so count holds.
          if (push_req) begin
            wr_en    = 1'b1;
            wr_ptr_d = wr_ptr_q + 1'b1;
          end else begin
            count_d = count_q - 1'b1;
          end
        end else if (push_req) begin
          out_d       = op_oh;
          out_valid_d = 1'b1;
        end else begin
          err_underflow_d = 1'b1;
        end
      end else begin
        if (push_req) begin
          if (count_q == CountMax) begin
            err_overflow_d = 1'b1;
          end else begin
            wr_en    = 1'b1;
            wr_ptr_d = wr_ptr_q + 1'b1;
            count_d  = count_q + 1'b1;
          end
        end
        if (got_dig) begin
          out_d       = '0;
          out_valid_d = 1'b0;
        end
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr_q        <= '0;
      rd_ptr_q        <= '0;
      count_q         <= '0;
      out_q           <= '0;
      out_valid_q     <= 1'b0;
      err_invalid_q   <= 1'b0;
      err_underflow_q <= 1'b0;
      err_overflow_q  <= 1'b0;
    end else begin
      wr_ptr_q        <= wr_ptr_d;
      rd_ptr_q        <= rd_ptr_d;
      count_q         <= count_d;
      out_q           <= out_d;
      out_valid_q     <= out_valid_d;
      err_invalid_q   <= err_invalid_d;
      err_underflow_q <= err_underflow_d;
      err_overflow_q  <= err_overflow_d;
    end
  end

  // Storage needs no reset; entries are only read after being written.
  always_ff @(posedge clk) begin
    if (wr_en) begin
      mem_q[wr_ptr_q] <= op_oh;
    end
  end

  assign out           = out_q;
  assign out_valid     = out_valid_q;
  assign count         = count_q;
  assign empty         = (count_q == '0);
  assign full          = (count_q == CountMax);
  assign err_invalid   = err_invalid_q;
  assign err_underflow = err_underflow_q;
  assign err_overflow  = err_overflow_q;

endmodule

// File: tb/tb_cmd_op_queue.sv
// Directed bench for cmd_op_queue: main instance with EXT_OPS=1, second instance with EXT_OPS=0.
module tb_cmd_op_queue;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       load_cmd = 1'b0;
  logic       rdy = 1'b0;
  logic       got_dig = 1'b0;
  logic       flush = 1'b0;
  logic [7:0] data = 8'h00;

  logic [5:0] out;
  logic       out_valid, empty, full, err_invalid, err_underflow, err_overflow;
  logic [2:0] count;

  logic [5:0] x_out;
  logic       x_out_valid, x_empty, x_full, x_err_invalid, x_err_underflow, x_err_overflow;
  logic [2:0] x_count;

  int n_tests = 0;
  int n_fail  = 0;

  always #5 clk = ~clk;

  cmd_op_queue #(.DEPTH(4), .AW(2), .EXT_OPS(1)) dut (
    .clk(clk), .rst(rst), .load_cmd(load_cmd), .rdy(rdy), .got_dig(got_dig), .flush(flush),
    .data(data), .out(out), .out_valid(out_valid), .count(count), .empty(empty), .full(full),
    .err_invalid(err_invalid), .err_underflow(err_underflow), .err_overflow(err_overflow)
  );

  cmd_op_queue #(.DEPTH(4), .AW(2), .EXT_OPS(0)) dut_x (
    .clk(clk), .rst(rst), .load_cmd(load_cmd), .rdy(rdy), .got_dig(got_dig), .flush(flush),
    .data(data), .out(x_out), .out_valid(x_out_valid), .count(x_count), .empty(x_empty),
    .full(x_full), .err_invalid(x_err_invalid), .err_underflow(x_err_underflow),
    .err_overflow(x_err_overflow)
  );

  task automatic step();
    @(posedge clk);
    #1;
    load_cmd = 1'b0;
    rdy      = 1'b0;
    got_dig  = 1'b0;
    flush    = 1'b0;
  endtask

  task automatic push(input logic [7:0] ch);
    load_cmd = 1'b1;
    data     = ch;
    step();
  endtask

  task automatic pop();
    rdy = 1'b1;
    step();
  endtask

  task automatic do_flush();
    flush = 1'b1;
    step();
  endtask

  task automatic test_reset();
    #12;
    rst = 1'b0;
    step();
    push(8'h2B);
    push(8'h2A);
    n_tests++; if (count !== 3'd2) begin n_fail++; $display("FAIL pre_reset_count got %0d want 2", count); end
    #1 rst = 1'b1;
    #1;
    n_tests++; if (count !== 3'd0) begin n_fail++; $display("FAIL reset_count got %0d want 0", count); end
    n_tests++; if ({out, out_valid, err_invalid, err_underflow, err_overflow} !== 10'd0) begin
      n_fail++; $display("FAIL reset_outputs got %b want 0",
                         {out, out_valid, err_invalid, err_underflow, err_overflow}); end
    n_tests++; if (empty !== 1'b1 || full !== 1'b0) begin
      n_fail++; $display("FAIL reset_flags got e=%b f=%b want e=1 f=0", empty, full); end
    #1 rst = 1'b0;
    pop();
    n_tests++; if (err_underflow !== 1'b1) begin
      n_fail++; $display("FAIL underflow_pulse got %b want 1", err_underflow); end
    n_tests++; if (out !== 6'd0 || out_valid !== 1'b0) begin
      n_fail++; $display("FAIL underflow_out got %h/%b want 00/0", out, out_valid); end
    step();
    n_tests++; if (err_underflow !== 1'b0) begin
      n_fail++; $display("FAIL underflow_clear got %b want 0", err_underflow); end
  endtask

  task automatic test_ordered();
    logic [5:0] exp [4];
    exp[0] = 6'h01; exp[1] = 6'h02; exp[2] = 6'h04; exp[3] = 6'h08;
    push(8'h2B); push(8'h2D); push(8'h2A); push(8'h2F);
    n_tests++; if (full !== 1'b1 || count !== 3'd4) begin
      n_fail++; $display("FAIL ordered_full got f=%b c=%0d want f=1 c=4", full, count); end
    for (int i = 0; i < 4; i++) begin
      pop();
      n_tests++; if (out !== exp[i] || out_valid !== 1'b1) begin
        n_fail++; $display("FAIL ordered_pop%0d got %h/%b want %h/1", i, out, out_valid, exp[i]); end
    end
    n_tests++; if (empty !== 1'b1 || count !== 3'd0) begin
      n_fail++; $display("FAIL ordered_empty got e=%b c=%0d want e=1 c=0", empty, count); end
  endtask

  task automatic test_overflow_wrap();
    logic [5:0] exp [4];
    exp[0] = 6'h04; exp[1] = 6'h08; exp[2] = 6'h20; exp[3] = 6'h01;
    push(8'h2B); push(8'h2D); push(8'h2A); push(8'h2F);
    push(8'h25);
    n_tests++; if (err_overflow !== 1'b1 || count !== 3'd4) begin
      n_fail++; $display("FAIL overflow_set got o=%b c=%0d want o=1 c=4", err_overflow, count); end
    pop(); pop();
    n_tests++; if (err_overflow !== 1'b1 || out !== 6'h02) begin
      n_fail++; $display("FAIL overflow_sticky got o=%b out=%h want o=1 out=02", err_overflow, out); end
    push(8'h5E); push(8'h2B);
    for (int i = 0; i < 4; i++) begin
      pop();
      n_tests++; if (out !== exp[i]) begin
        n_fail++; $display("FAIL wrap_pop%0d got %h want %h", i, out, exp[i]); end
    end
    do_flush();
    n_tests++; if (err_overflow !== 1'b0 || out_valid !== 1'b0 || out !== 6'd0) begin
      n_fail++; $display("FAIL flush_clear got o=%b v=%b out=%h want 0/0/00",
                         err_overflow, out_valid, out); end
  endtask

  task automatic test_back_to_back();
    load_cmd = 1'b1; data = 8'h2A; rdy = 1'b1;
    step();
    n_tests++; if (out !== 6'h04 || out_valid !== 1'b1 || count !== 3'd0 || err_underflow !== 1'b0) begin
      n_fail++; $display("FAIL bypass got out=%h v=%b c=%0d u=%b want 04/1/0/0",
                         out, out_valid, count, err_underflow); end
    push(8'h2B); push(8'h2D); push(8'h2A); push(8'h2F);
    load_cmd = 1'b1; data = 8'h5E; rdy = 1'b1;
    step();
    n_tests++; if (out !== 6'h01 || count !== 3'd4 || err_overflow !== 1'b0) begin
      n_fail++; $display("FAIL full_push_pop got out=%h c=%0d o=%b want 01/4/0",
                         out, count, err_overflow); end
    pop(); pop(); pop(); pop();
    n_tests++; if (out !== 6'h20 || empty !== 1'b1) begin
      n_fail++; $display("FAIL full_push_pop_tail got out=%h e=%b want 20/1", out, empty); end
    // flush with pending load/rdy must ignore both and raise nothing
    flush = 1'b1; load_cmd = 1'b1; data = 8'h41; rdy = 1'b1;
    step();
    n_tests++; if (count !== 3'd0 || err_invalid !== 1'b0 || err_underflow !== 1'b0 || out_valid !== 1'b0) begin
      n_fail++; $display("FAIL flush_priority got c=%0d i=%b u=%b v=%b want 0/0/0/0",
                         count, err_invalid, err_underflow, out_valid); end
  endtask

  task automatic test_ext_ops();
    push(8'h25);
    n_tests++; if (x_err_invalid !== 1'b1 || x_count !== 3'd0) begin
      n_fail++; $display("FAIL noext_mod got i=%b c=%0d want 1/0", x_err_invalid, x_count); end
    n_tests++; if (err_invalid !== 1'b0 || count !== 3'd1) begin
      n_fail++; $display("FAIL ext_mod got i=%b c=%0d want 0/1", err_invalid, count); end
    push(8'h41);
    n_tests++; if (err_invalid !== 1'b1 || x_err_invalid !== 1'b1 || count !== 3'd1) begin
      n_fail++; $display("FAIL invalid_A got i=%b xi=%b c=%0d want 1/1/1",
                         err_invalid, x_err_invalid, count); end
    step();
    n_tests++; if (err_invalid !== 1'b0) begin
      n_fail++; $display("FAIL invalid_pulse got %b want 0", err_invalid); end
    load_cmd = 1'b1; data = 8'h41; rdy = 1'b1;
    step();
    n_tests++; if (err_invalid !== 1'b1 || out !== 6'h10 || count !== 3'd0) begin
      n_fail++; $display("FAIL invalid_with_pop got i=%b out=%h c=%0d want 1/10/0",
                         err_invalid, out, count); end
    do_flush();
  endtask

  task automatic test_got_dig();
    push(8'h2D);
    pop();
    n_tests++; if (out !== 6'h02 || out_valid !== 1'b1) begin
      n_fail++; $display("FAIL gd_pre got %h/%b want 02/1", out, out_valid); end
    push(8'h2A);
    got_dig = 1'b1;
    step();
    n_tests++; if (out !== 6'd0 || out_valid !== 1'b0 || count !== 3'd1) begin
      n_fail++; $display("FAIL gd_clear got out=%h v=%b c=%0d want 00/0/1", out, out_valid, count); end
    got_dig = 1'b1; rdy = 1'b1;
    step();
    n_tests++; if (out !== 6'h04 || out_valid !== 1'b1 || count !== 3'd0) begin
      n_fail++; $display("FAIL gd_rdy_prio got out=%h v=%b c=%0d want 04/1/0", out, out_valid, count); end
  endtask

  initial begin
    test_reset();
    test_ordered();
    test_overflow_wrap();
    test_back_to_back();
    test_ext_ops();
    test_got_dig();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL timeout");
    $fatal(1);
  end

endmodule

// File: doc/cmd_op_queue.md
Name: cmd_op_queue

Overview:
- Parametrised successor to the calculator's single-register operator decoder.
- Decodes ASCII operator bytes from the keyboard/UART path into a one-hot op code and queues up to DEPTH pending operators, so chained expressions (e.g. "3+4*2-1") can be entered ahead of the arithmetic unit.
- Presents one operator per `rdy` to the ALU sequencer.
- Flags invalid characters, overflow and underflow.

Parameters:
- DEPTH, 4: number of queued operators; power of two, 2..16.
- AW, 2: pointer width, must equal log2(DEPTH).
- EXT_OPS, 1: 1 enables '%' (mod) and '^' (pow); 0 treats them as invalid.

Ports:
- clk  in  1  system clock, rising edge.
- rst  in  1  asynchronous, active-high reset.
- load_cmd  in  1  `data` holds an operator character this cycle.
- rdy  in  1  ALU sequencer requests next operator (pop).
- got_dig  in  1  new digit sequence started; clears presented op.
- flush  in  1  synchronous clear of queue and sticky error.
- data  in  8  ASCII character.
- out  out  6  one-hot op: [0] add '+' 0x2B, [1] sub '-' 0x2D, [2] mul '*' 0x2A, [3] div '/' 0x2F, [4] mod '%' 0x25, [5] pow '^' 0x5E.
- out_valid  out  1  `out` holds a popped operator.
- count  out  AW+1  number of queued entries, 0..DEPTH.
- empty  out  1  count==0.
- full  out  1  count==DEPTH.
- err_invalid  out  1  one-cycle pulse: `load_cmd` with a non-operator byte.
- err_underflow  out  1  one-cycle pulse: `rdy` with nothing to deliver.
- err_overflow  out  1  sticky: a push was dropped because the queue was full.

Behaviour:
- **Reset:** `rst` high asynchronously forces out=0, out_valid=0, count=0, read/write pointers=0, and all error outputs to 0. Storage contents are don't-care.
- All outputs are registered. `empty`/`full` derive from the registered `count`.
- **Decode:** the 4 basic ops are always valid. '%'/'^' are valid only if EXT_OPS=1. Any other byte with `load_cmd`=1 causes no push and err_invalid=1 the next cycle.
- **Push:** a valid op with `load_cmd` writes at the write pointer. The pointer wraps modulo DEPTH. `count` increments, visible the next cycle.
- **Pop:** `rdy` with count>0 loads the head into `out` and sets out_valid=1 (1-cycle latency). The read pointer advances and `count` decrements.
- **Underflow:** `rdy` with count==0 and no bypass leaves `out`/out_valid unchanged and pulses err_underflow.
- **Bypass:** `load_cmd` (valid) and `rdy` in the same cycle with count==0 sends the new op straight to `out` with out_valid=1. Count stays 0, no underflow.
- **Simultaneous push+pop with count>0:** both happen and count is unchanged. At count==DEPTH the push is accepted, because a slot is freed the same cycle.
- **Overflow:** a push with count==DEPTH and no pop is dropped and sets err_overflow, which holds until `flush` or `rst`.
- **got_dig:** with `rdy`=0, sets out=0 and out_valid=0 next cycle; the queue is unaffected. `rdy` has priority over `got_dig` when both are high.
- **flush:** highest synchronous priority. Sets count=0, resets pointers, out=0, out_valid=0 and err_overflow=0. A `load_cmd`/`rdy` in the same cycle is ignored, with no error pulses.
- Invalid char and `rdy` in the same cycle: the pop proceeds normally and err_invalid pulses.

Test Plan:
1. Reset mid-stream: push '+','*', assert `rst` asynchronously between edges -> all outputs 0 immediately, count=0; after release, `rdy` -> err_underflow pulse, out=0.
2. Ordered queue: push '+','-','*','/' (DEPTH=4) -> full=1, count=4; four `rdy` pulses -> out=0x01,0x02,0x04,0x08 in order, then empty=1.
3. Overflow and wrap: with the queue full, push '%' -> dropped, err_overflow=1 sticky. Pop 2, push '^','+' -> pointers wrap. Pops yield 0x04,0x08,0x20,0x01. `flush` clears err_overflow.
4. Bypass/simultaneous: empty queue, `load_cmd`='*' with `rdy` -> next cycle out=0x04, out_valid=1, count=0. At full, push+pop -> count stays 4, no overflow.
5. EXT_OPS=0: `load_cmd` '%' (0x25) -> err_invalid pulse, count unchanged. 'A' (0x41) -> err_invalid in both configs.
6. `got_dig`: after pop out=0x02, assert `got_dig` -> out=0, out_valid=0, count unchanged. `got_dig`+`rdy` with count=1 -> pop wins, out = head.
